// File: rtl/hash_word_scanner_pkg.sv
// Shared types and default geometry for the hash word scanner and its display driver.
package hash_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam int unsigned DEF_DATA_W = 256;
  localparam int unsigned DEF_WORD_W = 16;

endpackage

// File: rtl/hash_word_scanner_if.sv
// Control/data bundle between the hash core side and the word scanner.
interface hash_word_scanner_if
  import hash_scan_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WORD_W = DEF_WORD_W
) ();

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned SEL_W  = $clog2(NWORDS);

  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic              pause;
  logic [WORD_W-1:0] word_out;
  logic [SEL_W-1:0]  idx_out;
  logic              valid;
  logic              wrap;

  modport master (
    output load, data_in, mode, sel_in, pause,
    input  word_out, idx_out, valid, wrap
  );

  modport slave (
    input  load, data_in, mode, sel_in, pause,
    output word_out, idx_out, valid, wrap
  );

endinterface

// File: rtl/hash_word_scanner_tick_gen.sv
// Auto-scroll prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hash_word_scanner.sv
// Captures a wide hash result and presents one registered WORD_W slice at a time,
// chosen manually or by a self-advancing scroll index.
module hash_word_scanner
  import hash_scan_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned WORD_W   = DEF_WORD_W,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  hash_word_scanner_if.slave  bus
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned SEL_W  = $clog2(NWORDS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NWORDS - 1);

  mode_e             mode;
  logic              tick_clear, tick_en, tick;

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SEL_W-1:0]  idx_out_q, idx_out_d;

  assign mode       = mode_e'(bus.mode);
  // Load and manual mode both pin the prescaler at zero, so a load always beats a coincident tick.
  assign tick_clear = bus.load || (mode == MODE_MANUAL);
  assign tick_en    = (mode == MODE_AUTO) && !bus.pause;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  always_comb begin
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    word_d    = shadow_q[idx_q*WORD_W +: WORD_W];
    idx_out_d = idx_q;
    if (bus.load) begin
      shadow_d = bus.data_in;
      valid_d  = 1'b1;
      idx_d    = '0;
    end else if (mode == MODE_MANUAL) begin
      if (32'(bus.sel_in) >= NWORDS) begin
        idx_d = LAST;
      end else begin
        idx_d = bus.sel_in;
      end
    end else if (tick) begin
      if (idx_q == LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      word_q    <= '0;
      idx_out_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      word_q    <= word_d;
      idx_out_q <= idx_out_d;
    end
  end

  assign bus.word_out = word_q;
  assign bus.idx_out  = idx_out_q;
  assign bus.valid    = valid_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_hash_word_scanner.sv
// Bench for hash_word_scanner: 256/16 and 48/16 instances against a word-array reference model.
module tb_hash_word_scanner;

  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  hash_word_scanner_if #(.DATA_W(256), .WORD_W(16)) ifa ();
  hash_word_scanner_if #(.DATA_W(48),  .WORD_W(16)) ifb ();

  hash_word_scanner #(.DATA_W(256), .WORD_W(16), .TICK_DIV(TICK)) u_a (
    .clk(clk), .reset(rst_a), .bus(ifa));
  hash_word_scanner #(.DATA_W(48), .WORD_W(16), .TICK_DIV(TICK)) u_b (
    .clk(clk), .reset(rst_b), .bus(ifb));

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-instance word array, scroll position and cycles since last step.
  int          nw [2] = '{16, 3};
  logic [15:0] m_w    [2][16];
  int          m_idx  [2];
  int          m_cnt  [2];
  bit          m_valid[2];
  bit          m_wrap [2];
  logic [15:0] m_word [2];
  int          m_idxo [2];

  task automatic m_reset(input int d);
    for (int k = 0; k < 16; k++) m_w[d][k] = '0;
    m_idx[d] = 0; m_cnt[d] = 0; m_valid[d] = 0; m_wrap[d] = 0;
    m_word[d] = '0; m_idxo[d] = 0;
  endtask

  task automatic m_step(input int d, input bit ld, input logic [255:0] data,
                        input bit md, input int sel, input bit ps);
    m_word[d] = m_w[d][m_idx[d]];
    m_idxo[d] = m_idx[d];
    m_wrap[d] = 0;
    if (ld) begin
      for (int k = 0; k < nw[d]; k++) m_w[d][k] = data[k*16 +: 16];
      m_valid[d] = 1; m_idx[d] = 0; m_cnt[d] = 0;
    end else if (!md) begin
      m_idx[d] = (sel >= nw[d]) ? nw[d] - 1 : sel;
      m_cnt[d] = 0;
    end else if (!ps) begin
      if (m_cnt[d] == TICK - 1) begin
        m_cnt[d] = 0;
        if (m_idx[d] == nw[d] - 1) begin
          m_idx[d] = 0; m_wrap[d] = 1;
        end else begin
          m_idx[d]++;
        end
      end else begin
        m_cnt[d]++;
      end
    end
  endtask

  always @(posedge clk or posedge rst_a)
    if (rst_a) m_reset(0);
    else m_step(0, ifa.load, ifa.data_in, ifa.mode, int'(ifa.sel_in), ifa.pause);

  always @(posedge clk or posedge rst_b)
    if (rst_b) m_reset(1);
    else m_step(1, ifb.load, 256'(ifb.data_in), ifb.mode, int'(ifb.sel_in), ifb.pause);

  always @(negedge clk) begin
    check("a.word_out", ifa.word_out, m_word[0]);
    check("a.idx_out",  ifa.idx_out,  m_idxo[0]);
    check("a.valid",    ifa.valid,    m_valid[0]);
    check("a.wrap",     ifa.wrap,     m_wrap[0]);
    check("b.word_out", ifb.word_out, m_word[1]);
    check("b.idx_out",  ifb.idx_out,  m_idxo[1]);
    check("b.valid",    ifb.valid,    m_valid[1]);
    check("b.wrap",     ifb.wrap,     m_wrap[1]);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [255:0] dA, dB, rnd;
  int n, wraps, last_chg, prev_idx;
  bit seen;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.load = 0; ifa.data_in = '0; ifa.mode = 0; ifa.sel_in = '0; ifa.pause = 0;
    ifb.load = 0; ifb.data_in = '0; ifb.mode = 0; ifb.sel_in = '0; ifb.pause = 0;
    for (int k = 0; k < 16; k++) dA[k*16 +: 16] = 16'hA000 + 16'(k);
    dB = '0;
    for (int k = 0; k < 16; k++) dB[k*16 +: 16] = 16'hB000 + 16'(k);
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // 1: idle after reset
    repeat (5) @(negedge clk);
    check("t1.word_out", ifa.word_out, 0);
    check("t1.idx_out",  ifa.idx_out,  0);
    check("t1.valid",    ifa.valid,    0);

    // 2: load then manual sel 5
    ifa.load = 1; ifa.data_in = dA;
    @(negedge clk);
    ifa.load = 0; ifa.sel_in = 4'd5;
    @(negedge clk);
    check("t2.word_out_first", ifa.word_out, 16'hA000);
    check("t2.idx_out_first",  ifa.idx_out,  0);
    @(negedge clk);
    check("t2.word_out", ifa.word_out, 16'hA005);
    check("t2.idx_out",  ifa.idx_out,  5);
    check("t2.valid",    ifa.valid,    1);

    // 3: auto scroll from a fresh load
    ifa.load = 1; ifa.mode = 1;
    @(negedge clk);
    ifa.load = 0;
    wraps = 0; last_chg = -1; prev_idx = int'(ifa.idx_out);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (ifa.wrap) wraps++;
      if (int'(ifa.idx_out) != prev_idx) begin
        if (last_chg >= 0) check("t3.step_period", c - last_chg, TICK);
        last_chg = c;
        prev_idx = int'(ifa.idx_out);
      end
    end
    check("t3.wrap_count", wraps, 1);

    // 4: pause right after stepping to 7
    n = 0;
    while (!(m_idx[0] == 7 && m_cnt[0] == 0) && n < 100) begin @(negedge clk); n++; end
    check("t4.reach_idx7", n < 100, 1);
    ifa.pause = 1;
    repeat (10) @(negedge clk);
    check("t4.idx_hold",  ifa.idx_out,  7);
    check("t4.word_hold", ifa.word_out, 16'hA007);
    ifa.pause = 0;
    n = 0;
    while (ifa.idx_out != 4'd8 && n < 20) begin @(negedge clk); n++; end
    // idx steps 4 edges after release; idx_out follows one edge later
    check("t4.resume_latency", n, TICK + 1);

    // 5: load coinciding with the 15->0 terminal tick
    n = 0;
    while (!(m_idx[0] == 15 && m_cnt[0] == TICK - 1) && n < 100) begin @(negedge clk); n++; end
    check("t5.reach_term", n < 100, 1);
    ifa.load = 1; ifa.data_in = dB;
    @(negedge clk);
    ifa.load = 0;
    check("t5.no_wrap", ifa.wrap, 0);
    @(negedge clk);
    check("t5.no_wrap2", ifa.wrap, 0);
    check("t5.word_out", ifa.word_out, 16'hB000);
    check("t5.idx_out",  ifa.idx_out,  0);

    // 6: three-word instance: clamp, wrap, async reset
    ifb.load = 1; ifb.data_in = 48'hC002_C001_C000;
    @(negedge clk);
    ifb.load = 0; ifb.sel_in = 2'd3;
    repeat (2) @(negedge clk);
    check("t6.clamp_idx",  ifb.idx_out,  2);
    check("t6.clamp_word", ifb.word_out, 16'hC002);
    ifb.mode = 1;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (ifb.wrap) seen = 1;
    end
    check("t6.wrap_seen", seen, 1);
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b1;
    #1;
    check("t6.rst_word",  ifb.word_out, 0);
    check("t6.rst_idx",   ifb.idx_out,  0);
    check("t6.rst_valid", ifb.valid,    0);
    check("t6.rst_wrap",  ifb.wrap,     0);
    @(negedge clk);
    rst_b = 1'b0;
    ifb.load = 1; ifb.data_in = 48'h1234_5678_9ABC;
    @(negedge clk);
    ifb.load = 0;
    check("t6.reload_valid", ifb.valid, 1);
    @(negedge clk);
    check("t6.reload_word", ifb.word_out, 16'h9ABC);

    // Randomised traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 8; j++) rnd[j*32 +: 32] = $urandom;
      ifa.load    = ($urandom_range(0, 15) == 0);
      ifa.data_in = rnd;
      if ($urandom_range(0, 19) == 0) ifa.mode = ~ifa.mode;
      ifa.sel_in  = 4'($urandom_range(0, 15));
      ifa.pause   = ($urandom_range(0, 3) == 0);
      ifb.load    = ($urandom_range(0, 15) == 0);
      ifb.data_in = rnd[255:208];
      if ($urandom_range(0, 19) == 0) ifb.mode = ~ifb.mode;
      ifb.sel_in  = 2'($urandom_range(0, 3));
      ifb.pause   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    ifa.load = 0; ifb.load = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
